// File: rtl/ay_bus_master_if.sv
// Host command/response and AY bus signals of ay_bus_master, grouped as one bundle.
// The master modport is the bus initiator; the slave modport is the host/responder side.
interface ay_bus_master_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic       CMD_CHIP;
  logic [7:0] CMD_ADDR;
  logic [7:0] CMD_DATA;
  logic       FM_ENA;
  logic       STAT_SEL;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       ERR;
  logic       BDIR;
  logic       BC;
  logic [7:0] BUS_DO;
  logic [7:0] BUS_DI;

  modport master (
    input  CMD_VALID, CMD_OP, CMD_CHIP, CMD_ADDR, CMD_DATA, FM_ENA, STAT_SEL, BUS_DI,
    output CMD_READY, RSP_VALID, RSP_DATA, ERR, BDIR, BC, BUS_DO
  );

  modport slave (
    output CMD_VALID, CMD_OP, CMD_CHIP, CMD_ADDR, CMD_DATA, FM_ENA, STAT_SEL, BUS_DI,
    input  CMD_READY, RSP_VALID, RSP_DATA, ERR, BDIR, BC, BUS_DO
  );
endinterface

// File: rtl/ay_bus_master.sv
// Turbosound AY/YM bus initiator: one host command at a time becomes HOLD-cycle BDIR/BC phases,
// each followed by GAP idle cycles; READY is low for the whole sequence and busy commands are ignored.
module ay_bus_master #(
  parameter int HOLD = 4,
  parameter int GAP  = 4
) (
  input logic               CLK,
  input logic               RESET_s,
  ay_bus_master_if.master   io_bus
);

  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [7:0]    CTRL_RST  = 8'hFB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_ADDR,
    S_WDATA,
    S_RD,
    S_ERR
  } state_t;

  state_t        r_state;
  logic          r_gap;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_op;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic [7:0]    r_ctrl;
  logic [7:0]    r_cur_ctrl;
  logic          r_ready;
  logic          r_rsp_vld;
  logic [7:0]    r_rsp_dat;
  logic          r_err;
  logic          r_bdir;
  logic          r_bc;
  logic [7:0]    r_do;

  logic       w_accept;
  logic [7:0] w_ctrl;
  logic       w_bad;

  assign w_accept = io_bus.CMD_VALID & r_ready;
  assign w_ctrl   = {5'b11111, ~io_bus.FM_ENA, io_bus.STAT_SEL, io_bus.CMD_CHIP};
  // Addresses F8..FF would be decoded by the responder as a control write.
  assign w_bad    = (io_bus.CMD_OP == 2'b11) ||
                    ((io_bus.CMD_OP != 2'b10) && (io_bus.CMD_ADDR[7:3] == 5'b11111));

  always_ff @(posedge CLK or posedge RESET_s) begin
    if (RESET_s) begin
      r_state    <= S_IDLE;
      r_gap      <= 1'b0;
      r_cnt      <= '0;
      r_op       <= 2'b00;
      r_addr     <= 8'h00;
      r_data     <= 8'h00;
      r_ctrl     <= CTRL_RST;
      r_cur_ctrl <= CTRL_RST;
      r_ready    <= 1'b1;
      r_rsp_vld  <= 1'b0;
      r_rsp_dat  <= 8'h00;
      r_err      <= 1'b0;
      r_bdir     <= 1'b0;
      r_bc       <= 1'b0;
      r_do       <= 8'h00;
    end else begin
      r_rsp_vld <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= io_bus.CMD_OP;
            r_addr  <= io_bus.CMD_ADDR;
            r_data  <= io_bus.CMD_DATA;
            r_ctrl  <= w_ctrl;
            r_cnt   <= '0;
            r_gap   <= 1'b0;
            r_ready <= 1'b0;
            if (w_bad) begin
              r_state   <= S_ERR;
              r_rsp_vld <= 1'b1;
              r_err     <= 1'b1;
            end else if ((io_bus.CMD_OP == 2'b10) || (w_ctrl != r_cur_ctrl)) begin
              r_state <= S_CTRL;
              r_bdir  <= 1'b1;
              r_bc    <= 1'b1;
              r_do    <= w_ctrl;
            end else begin
              r_state <= S_ADDR;
              r_bdir  <= 1'b1;
              r_bc    <= 1'b1;
              r_do    <= io_bus.CMD_ADDR;
            end
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_gap) begin
            if (r_cnt == HOLD_LAST) begin
              r_cnt  <= '0;
              r_gap  <= 1'b1;
              r_bdir <= 1'b0;
              r_bc   <= 1'b0;
              if (r_state == S_CTRL) r_cur_ctrl <= r_ctrl;
              if (r_state == S_RD) begin
                r_rsp_dat <= io_bus.BUS_DI;
                r_rsp_vld <= 1'b1;
              end
            end
          end else if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            r_gap <= 1'b0;
            case (r_state)
              S_CTRL: begin
                if (r_op == 2'b10) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                end else begin
                  r_state <= S_ADDR;
                  r_bdir  <= 1'b1;
                  r_bc    <= 1'b1;
                  r_do    <= r_addr;
                end
              end
              S_ADDR: begin
                if (r_op == 2'b00) begin
                  r_state <= S_WDATA;
                  r_bdir  <= 1'b1;
                  r_bc    <= 1'b0;
                  r_do    <= r_data;
                end else begin
                  r_state <= S_RD;
                  r_bdir  <= 1'b0;
                  r_bc    <= 1'b1;
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign io_bus.CMD_READY = r_ready;
  assign io_bus.RSP_VALID = r_rsp_vld;
  assign io_bus.RSP_DATA  = r_rsp_dat;
  assign io_bus.ERR       = r_err;
  assign io_bus.BDIR      = r_bdir;
  assign io_bus.BC        = r_bc;
  assign io_bus.BUS_DO    = r_do;

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: directed vector table, mid-phase reset sequence and random commands,
// each checked cycle by cycle against a phase-list model of the bus protocol.
module tb_ay_bus_master;
  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int PER  = HOLD + GAP;
  localparam int MAXC = 64;
  localparam int NV   = 11;

  logic CLK = 1'b0;
  logic RESET_s = 1'b1;

  ay_bus_master_if bus ();

  ay_bus_master #(.HOLD(HOLD), .GAP(GAP)) dut (
    .CLK     (CLK),
    .RESET_s (RESET_s),
    .io_bus  (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] m_cur_ctrl;
  logic [7:0] m_last_do;
  logic       m_err;
  int         m_busy;
  int         m_rsp_cyc;
  logic       e_bd [0:MAXC];
  logic       e_bc [0:MAXC];
  logic [7:0] e_do [0:MAXC];
  logic [7:0] di_tr [0:MAXC];

  // observations of the last command
  int         o_busy;
  int         o_rsp_n;
  int         o_rsp_cyc;
  int         o_err_cyc;
  logic [7:0] o_do1;
  logic [7:0] o_rdat;

  typedef struct {
    logic [1:0] op;
    logic       chip;
    logic [7:0] addr;
    logic [7:0] data;
    logic       fm;
    logic       st;
    logic [7:0] di;
    int         exp_busy;
    logic [7:0] exp_do1;
    int         exp_rsp;
    int         exp_err;
    logic [7:0] exp_rdat;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_cur_ctrl = 8'hFB;
    m_last_do  = 8'h00;
  endtask

  // Builds the list of bus phases a command should produce, then expands it per cycle.
  task automatic model_cmd(input logic [1:0] op, input logic chip, input logic [7:0] addr,
                           input logic [7:0] data, input logic fm, input logic st);
    logic [7:0] c;
    logic       pbd [3];
    logic       pbc [3];
    logic [7:0] pdo [3];
    int         n;
    int         k;
    c = {5'b11111, ~fm, st, chip};
    n = 0;
    m_err = (op == 2'b11) || ((op != 2'b10) && (addr[7:3] == 5'b11111));
    if (!m_err) begin
      if ((op == 2'b10) || (c != m_cur_ctrl)) begin
        pbd[n] = 1'b1; pbc[n] = 1'b1; pdo[n] = c; n++;
        m_cur_ctrl = c;
      end
      if (op != 2'b10) begin
        pbd[n] = 1'b1; pbc[n] = 1'b1; pdo[n] = addr; n++;
        if (op == 2'b00) begin
          pbd[n] = 1'b1; pbc[n] = 1'b0; pdo[n] = data;
        end else begin
          pbd[n] = 1'b0; pbc[n] = 1'b1; pdo[n] = addr;
        end
        n++;
      end
    end
    k = 1;
    for (int p = 0; p < n; p++) begin
      for (int j = 0; j < PER; j++) begin
        e_bd[k] = (j < HOLD) ? pbd[p] : 1'b0;
        e_bc[k] = (j < HOLD) ? pbc[p] : 1'b0;
        e_do[k] = pdo[p];
        k++;
      end
    end
    if (n > 0) m_last_do = pdo[n-1];
    if (m_err) begin
      e_bd[1] = 1'b0; e_bc[1] = 1'b0; e_do[1] = m_last_do;
    end
    m_busy    = m_err ? 1 : n * PER;
    m_rsp_cyc = m_err ? 1 : ((op == 2'b01) ? n * PER - GAP + 1 : 0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic chip, input logic [7:0] addr,
                         input logic [7:0] data, input logic fm, input logic st,
                         input logic [7:0] di, input bit rand_di, input bit bb, input bit hold_v);
    int mism;
    model_cmd(op, chip, addr, data, fm, st);
    if (!bb) @(negedge CLK);
    bus.CMD_OP    = op;
    bus.CMD_CHIP  = chip;
    bus.CMD_ADDR  = addr;
    bus.CMD_DATA  = data;
    bus.FM_ENA    = fm;
    bus.STAT_SEL  = st;
    bus.BUS_DI    = di;
    bus.CMD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    if (hold_v) begin
      // a held request with different fields must neither be queued nor disturb the latched command
      bus.CMD_ADDR = ~addr;
      bus.CMD_DATA = ~data;
      bus.CMD_CHIP = ~chip;
      bus.FM_ENA   = ~fm;
    end else begin
      bus.CMD_VALID = 1'b0;
    end
    o_busy = -1; o_rsp_n = 0; o_rsp_cyc = 0; o_err_cyc = 0; mism = 0;
    o_do1 = 8'h00; o_rdat = 8'h00;
    for (int cyc = 1; cyc <= MAXC; cyc++) begin
      @(negedge CLK);
      if (bus.RSP_VALID) begin
        o_rsp_n++;
        o_rsp_cyc = cyc;
        o_rdat = bus.RSP_DATA;
      end
      if (bus.ERR) o_err_cyc = cyc;
      if (bus.CMD_READY) begin
        if (bus.BDIR || bus.BC) mism++;
        o_busy = cyc - 1;
        break;
      end
      if (cyc == 1) o_do1 = bus.BUS_DO;
      if (cyc <= m_busy) begin
        if ((bus.BDIR !== e_bd[cyc]) || (bus.BC !== e_bc[cyc]) || (bus.BUS_DO !== e_do[cyc])) mism++;
      end else begin
        mism++;
      end
      if (rand_di) bus.BUS_DI = 8'($urandom);
      di_tr[cyc] = bus.BUS_DI;
    end
    bus.CMD_VALID = 1'b0;
    chk("busy_cycles", o_busy, m_busy);
    chk("bus_trace_mismatches", mism, 0);
    chk("rsp_cycle", o_rsp_cyc, m_rsp_cyc);
    chk("rsp_count", o_rsp_n, (m_rsp_cyc != 0) ? 1 : 0);
    chk("err_cycle", o_err_cyc, m_err ? 1 : 0);
    if ((op == 2'b01) && !m_err) chk("rsp_data", int'(o_rdat), int'(di_tr[m_busy - GAP]));
  endtask

  initial begin
    vec_t v;
    logic [1:0] rop;
    int r;
    logic [7:0] raddr;

    tbl[0]  = '{2'b00, 1'b1, 8'h07, 8'h38, 1'b1, 1'b1, 8'h00, 16, 8'h07, 0, 0, 8'h00};
    tbl[1]  = '{2'b00, 1'b0, 8'h00, 8'h55, 1'b1, 1'b1, 8'h00, 24, 8'hFA, 0, 0, 8'h00};
    tbl[2]  = '{2'b00, 1'b0, 8'h00, 8'h55, 1'b1, 1'b1, 8'h00, 16, 8'h00, 0, 0, 8'h00};
    tbl[3]  = '{2'b01, 1'b0, 8'h0E, 8'h00, 1'b1, 1'b1, 8'hA5, 16, 8'h0E, 1, 0, 8'hA5};
    tbl[4]  = '{2'b00, 1'b0, 8'hF9, 8'h12, 1'b1, 1'b1, 8'h00,  1, 8'h00, 1, 1, 8'h00};
    tbl[5]  = '{2'b11, 1'b0, 8'h10, 8'h12, 1'b1, 1'b1, 8'h00,  1, 8'h00, 1, 1, 8'h00};
    tbl[6]  = '{2'b10, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00,  8, 8'hFA, 0, 0, 8'h00};
    tbl[7]  = '{2'b10, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00,  8, 8'hFD, 0, 0, 8'h00};
    tbl[8]  = '{2'b01, 1'b1, 8'hF8, 8'h00, 1'b0, 1'b0, 8'h00,  1, 8'h00, 1, 1, 8'h00};
    tbl[9]  = '{2'b00, 1'b1, 8'h1F, 8'hC3, 1'b0, 1'b0, 8'h00, 16, 8'h1F, 0, 0, 8'h00};
    tbl[10] = '{2'b01, 1'b1, 8'h03, 8'h00, 1'b1, 1'b0, 8'h3C, 24, 8'hF9, 1, 0, 8'h3C};

    bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'b00; bus.CMD_CHIP = 1'b0;
    bus.CMD_ADDR = 8'h00; bus.CMD_DATA = 8'h00; bus.FM_ENA = 1'b0;
    bus.STAT_SEL = 1'b0; bus.BUS_DI = 8'h00;
    model_reset();

    repeat (3) @(negedge CLK);
    RESET_s = 1'b0;
    @(negedge CLK);
    chk("rst_bdir", int'(bus.BDIR), 0);
    chk("rst_bc", int'(bus.BC), 0);
    chk("rst_bus_do", int'(bus.BUS_DO), 0);
    chk("rst_ready", int'(bus.CMD_READY), 1);
    chk("rst_rsp_valid", int'(bus.RSP_VALID), 0);
    chk("rst_err", int'(bus.ERR), 0);
    chk("rst_rsp_data", int'(bus.RSP_DATA), 0);

    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      run_cmd(v.op, v.chip, v.addr, v.data, v.fm, v.st, v.di, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_busy", i), o_busy, v.exp_busy);
      if (v.exp_busy > 1) chk($sformatf("vec%0d_first_do", i), int'(o_do1), int'(v.exp_do1));
      chk($sformatf("vec%0d_rsp", i), o_rsp_n, v.exp_rsp);
      chk($sformatf("vec%0d_err", i), (o_err_cyc != 0) ? 1 : 0, v.exp_err);
      if ((v.exp_rsp != 0) && (v.exp_err == 0))
        chk($sformatf("vec%0d_rsp_data", i), int'(o_rdat), int'(v.exp_rdat));
    end

    // back-to-back command issued in the READY cycle, with the request held high while busy
    run_cmd(2'b00, 1'b1, 8'h21, 8'h9C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    run_cmd(2'b01, 1'b1, 8'h22, 8'h00, 1'b1, 1'b0, 8'h6B, 1'b0, 1'b1, 1'b0);

    // reset asserted during the WDATA phase
    run_cmd(2'b10, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    bus.CMD_OP = 2'b00; bus.CMD_CHIP = 1'b0; bus.CMD_ADDR = 8'h02; bus.CMD_DATA = 8'h11;
    bus.FM_ENA = 1'b1; bus.STAT_SEL = 1'b1; bus.CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 bus.CMD_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    chk("wdata_bdir", int'(bus.BDIR), 1);
    chk("wdata_bc", int'(bus.BC), 0);
    chk("wdata_do", int'(bus.BUS_DO), 8'h11);
    RESET_s = 1'b1;
    #1;
    chk("midrst_bdir", int'(bus.BDIR), 0);
    chk("midrst_bc", int'(bus.BC), 0);
    chk("midrst_ready", int'(bus.CMD_READY), 1);
    chk("midrst_bus_do", int'(bus.BUS_DO), 0);
    chk("midrst_rsp_valid", int'(bus.RSP_VALID), 0);
    @(negedge CLK);
    RESET_s = 1'b0;
    model_reset();
    run_cmd(2'b00, 1'b0, 8'h02, 8'h11, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("postrst_busy", o_busy, 3 * PER);
    chk("postrst_ctrl_do", int'(o_do1), 8'hFA);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      rop = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      raddr = 8'($urandom);
      if ($urandom_range(0, 5) == 0) raddr = raddr | 8'hF8;
      run_cmd(rop, 1'($urandom), raddr, 8'($urandom),
              ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
              1'b1, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end
endmodule
